// File: rtl/stack_sequencer_fsm.sv
// Stack sequencer for CALL/RET/RTI and interrupt entry; drives memory-stage push/pop control.
// Optional STACK_GUARD_EN macro enables depth checking at acceptance and the sticky stack_fault flag.
module stack_sequencer_fsm #(
  parameter int unsigned STACK_DEPTH = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [1:0] op_code,
  output logic       op_ready,
  input  logic       int_req,
  output logic       busy,
  output logic       stall,
  output logic       done,
  output logic       memory_read,
  output logic       memory_write,
  output logic       memory_push,
  output logic       memory_pop,
  output logic [1:0] memory_address_select,
  output logic [1:0] memory_write_src_select,
  output logic       pc_choose_memory,
  output logic       interrupt,
  output logic       flags_restore,
  output logic       stack_fault
);

  localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH_HI,
    S_PUSH_LO,
    S_PUSH_FLAGS,
    S_VECTOR,
    S_POP_FLAGS,
    S_POP_LO,
    S_POP_HI,
    S_LOAD_PC,
    S_NOP,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic          int_seq_q, int_seq_d;
  logic          int_pend_q, int_pend_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          call_ok, int_ok, ret_ok, rti_ok;
  logic          push_cyc, pop_cyc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      int_seq_q  <= 1'b0;
      int_pend_q <= 1'b0;
      depth_q    <= '0;
    end else begin
      state_q    <= state_d;
      int_seq_q  <= int_seq_d;
      int_pend_q <= int_pend_d;
      depth_q    <= depth_d;
    end
  end

`ifdef STACK_GUARD_EN
  logic stack_fault_q, stack_fault_d;

  always_comb begin
    call_ok = (depth_q <= DW'(STACK_DEPTH - 2));
    int_ok  = (depth_q <= DW'(STACK_DEPTH - 3));
    ret_ok  = (depth_q >= DW'(2));
    rti_ok  = (depth_q >= DW'(3));
    stack_fault_d = stack_fault_q | ((state_q == S_IDLE) && (state_d == S_FAULT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stack_fault_q <= 1'b0;
    else       stack_fault_q <= stack_fault_d;
  end

  assign stack_fault = stack_fault_q;
`else
  always_comb begin
    call_ok = 1'b1;
    int_ok  = 1'b1;
    ret_ok  = 1'b1;
    rti_ok  = 1'b1;
  end

  assign stack_fault = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    int_seq_d  = int_seq_q;
    int_pend_d = int_pend_q;
    if (state_q != S_IDLE && int_req) int_pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        // Interrupt wins over a pending op; a rejected INT still consumes the pending flag.
        if (int_req || int_pend_q) begin
          int_pend_d = 1'b0;
          int_seq_d  = 1'b1;
          state_d    = int_ok ? S_PUSH_HI : S_FAULT;
        end else if (op_valid) begin
          int_seq_d = 1'b0;
          unique case (op_code)
            2'b00:   state_d = call_ok ? S_PUSH_HI   : S_FAULT;
            2'b01:   state_d = ret_ok  ? S_POP_LO    : S_FAULT;
            2'b10:   state_d = rti_ok  ? S_POP_FLAGS : S_FAULT;
            default: state_d = S_NOP;
          endcase
        end
      end
      S_PUSH_HI:    state_d = S_PUSH_LO;
      S_PUSH_LO:    state_d = int_seq_q ? S_PUSH_FLAGS : S_IDLE;
      S_PUSH_FLAGS: state_d = S_VECTOR;
      S_POP_FLAGS:  state_d = S_POP_LO;
      S_POP_LO:     state_d = S_POP_HI;
      S_POP_HI:     state_d = S_LOAD_PC;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push_cyc = (state_q == S_PUSH_HI) || (state_q == S_PUSH_LO) || (state_q == S_PUSH_FLAGS);
    pop_cyc  = (state_q == S_POP_FLAGS) || (state_q == S_POP_LO) || (state_q == S_POP_HI);
    depth_d  = depth_q;
    if (push_cyc && depth_q != DW'(STACK_DEPTH)) depth_d = depth_q + DW'(1);
    else if (pop_cyc && depth_q != '0)           depth_d = depth_q - DW'(1);
  end

  always_comb begin
    op_ready                = (state_q == S_IDLE) && !(int_req || int_pend_q) && !reset;
    busy                    = (state_q != S_IDLE);
    stall                   = (state_q != S_IDLE);
    done                    = 1'b0;
    memory_read             = 1'b0;
    memory_write            = 1'b0;
    memory_push             = 1'b0;
    memory_pop              = 1'b0;
    memory_address_select   = 2'b00;
    memory_write_src_select = 2'b00;
    pc_choose_memory        = 1'b0;
    interrupt               = 1'b0;
    flags_restore           = 1'b0;
    unique case (state_q)
      S_PUSH_HI, S_PUSH_LO, S_PUSH_FLAGS: begin
        memory_write          = 1'b1;
        memory_push           = 1'b1;
        memory_address_select = 2'b10;
        if (state_q == S_PUSH_HI)      memory_write_src_select = 2'b01;
        else if (state_q == S_PUSH_LO) memory_write_src_select = 2'b10;
        done = (state_q == S_PUSH_LO) && !int_seq_q;
      end
      S_POP_FLAGS, S_POP_LO, S_POP_HI: begin
        memory_read           = 1'b1;
        memory_pop            = 1'b1;
        memory_address_select = 2'b10;
        flags_restore         = (state_q == S_POP_FLAGS);
      end
      S_VECTOR: begin
        interrupt = 1'b1;
        done      = 1'b1;
      end
      S_LOAD_PC: begin
        pc_choose_memory = 1'b1;
        done             = 1'b1;
      end
      S_NOP, S_FAULT: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stack_sequencer_fsm.sv
// Directed bench for stack_sequencer_fsm with a small memory-stage model (stack, PC shift register, flags).
// Output vector bit order: op_ready busy stall done rd wr push pop as[1:0] ws[1:0] pcm intr frest fault.
module tb_stack_sequencer_fsm;

  logic       clk = 1'b0;
  logic       reset, op_valid, int_req;
  logic [1:0] op_code;
  logic       op_ready, busy, stall, done;
  logic       memory_read, memory_write, memory_push, memory_pop;
  logic [1:0] memory_address_select, memory_write_src_select;
  logic       pc_choose_memory, interrupt, flags_restore, stack_fault;

  stack_sequencer_fsm #(.STACK_DEPTH(1024)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .int_req(int_req), .busy(busy), .stall(stall), .done(done),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .memory_address_select(memory_address_select),
    .memory_write_src_select(memory_write_src_select),
    .pc_choose_memory(pc_choose_memory), .interrupt(interrupt),
    .flags_restore(flags_restore), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] V_IDLE   = 16'h8000;
  localparam logic [15:0] V_IDLE_N = 16'h0000;
  localparam logic [15:0] V_PHI    = 16'h6690;
  localparam logic [15:0] V_PLO_D  = 16'h76A0;
  localparam logic [15:0] V_PLO    = 16'h66A0;
  localparam logic [15:0] V_PFL    = 16'h6680;
  localparam logic [15:0] V_VEC    = 16'h7004;
  localparam logic [15:0] V_POPF   = 16'h6982;
  localparam logic [15:0] V_POP    = 16'h6980;
  localparam logic [15:0] V_LDPC   = 16'h7008;
  localparam logic [15:0] V_NOP    = 16'h7000;

  logic [15:0] outv;
  assign outv = {op_ready, busy, stall, done, memory_read, memory_write, memory_push, memory_pop,
                 memory_address_select, memory_write_src_select,
                 pc_choose_memory, interrupt, flags_restore, stack_fault};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory-stage model: push stores the selected source, pop fills the PC shift register or flags.
  logic [15:0] mem [0:15];
  int          sp;
  logic [31:0] sr;
  logic [31:0] pc;
  logic [2:0]  flags;
  logic [15:0] wd, rd;

  always @(negedge clk) begin
    if (reset) begin
      sp = 0;
    end else begin
      if (memory_push && sp < 16) begin
        case (memory_write_src_select)
          2'b01:   wd = pc[31:16];
          2'b10:   wd = pc[15:0];
          default: wd = {13'd0, flags};
        endcase
        mem[sp] = wd;
        sp++;
      end
      if (memory_pop && sp > 0) begin
        sp--;
        rd = mem[sp];
        if (flags_restore) flags = rd[2:0];
        else               sr = {rd, sr[31:16]};
      end
    end
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; int_req = 1'b0;
    flags = 3'b101; sr = '0; pc = 32'h0001_2345; sp = 0;
    #2;
    check_eq("rst_outputs", outv, 16'h0000);
    check_eq("rst_depth", dut.depth_q, 0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("idle_after_rst", outv, V_IDLE);

    // CALL
    op_valid = 1'b1; op_code = 2'b00;
    tick();
    op_valid = 1'b0; op_code = 2'b11;
    check_eq("call_c1", outv, V_PHI);
    tick(); check_eq("call_c2", outv, V_PLO_D);
    tick(); check_eq("call_idle", outv, V_IDLE);
    check_eq("call_depth", dut.depth_q, 2);

    // RET; op_code changes while busy must be ignored
    op_valid = 1'b1; op_code = 2'b01;
    tick();
    op_valid = 1'b0; op_code = 2'b10;
    check_eq("ret_c1", outv, V_POP);
    tick(); check_eq("ret_c2", outv, V_POP);
    tick(); check_eq("ret_c3", outv, V_LDPC);
    check_eq("ret_pc", sr, 32'h0001_2345);
    tick(); check_eq("ret_idle", outv, V_IDLE);
    check_eq("ret_depth", dut.depth_q, 0);

    // Interrupt from idle
    int_req = 1'b1;
    #1;
    check_eq("int_idle_ready", outv, V_IDLE_N);
    tick();
    int_req = 1'b0;
    check_eq("int_c1", outv, V_PHI);
    tick(); check_eq("int_c2", outv, V_PLO);
    tick(); check_eq("int_c3", outv, V_PFL);
    tick(); check_eq("int_c4", outv, V_VEC);
    tick(); check_eq("int_idle", outv, V_IDLE);
    check_eq("int_depth", dut.depth_q, 3);

    // RTI restores flags and PC
    flags = 3'b000; sr = '0;
    op_valid = 1'b1; op_code = 2'b10;
    tick();
    op_valid = 1'b0;
    check_eq("rti_c1", outv, V_POPF);
    tick(); check_eq("rti_c2", outv, V_POP);
    tick(); check_eq("rti_c3", outv, V_POP);
    tick(); check_eq("rti_c4", outv, V_LDPC);
    check_eq("rti_pc", sr, 32'h0001_2345);
    tick(); check_eq("rti_idle", outv, V_IDLE);
    check_eq("rti_flags", flags, 3'b101);
    check_eq("rti_depth", dut.depth_q, 0);

    // int_req during CALL cycle 1; a held op waits behind the interrupt
    pc = 32'h00AB_CDEF;
    op_valid = 1'b1; op_code = 2'b00;
    tick();
    op_valid = 1'b0;
    check_eq("pend_call_c1", outv, V_PHI);
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    check_eq("pend_call_c2", outv, V_PLO_D);
    tick(); check_eq("pend_idle_gap", outv, V_IDLE_N);
    op_valid = 1'b1; op_code = 2'b11;
    tick(); check_eq("pend_int_c1", outv, V_PHI);
    tick(); check_eq("pend_int_c2", outv, V_PLO);
    tick(); check_eq("pend_int_c3", outv, V_PFL);
    tick(); check_eq("pend_int_c4", outv, V_VEC);
    tick(); check_eq("pend_idle_ready", outv, V_IDLE);
    tick();
    op_valid = 1'b0;
    check_eq("held_nop", outv, V_NOP);
    tick(); check_eq("nop_idle", outv, V_IDLE);
    check_eq("pend_depth", dut.depth_q, 5);

    // Reset during RTI cycle 2
    op_valid = 1'b1; op_code = 2'b10;
    tick();
    op_valid = 1'b0;
    check_eq("abort_c1", outv, V_POPF);
    tick();
    check_eq("abort_c2", outv, V_POP);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_outputs", outv, 16'h0000);
    check_eq("abort_depth", dut.depth_q, 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("abort_idle", outv, V_IDLE);

`ifdef STACK_GUARD_EN
    // RET at depth 0 is rejected and faults
    op_valid = 1'b1; op_code = 2'b01;
    tick();
    op_valid = 1'b0;
    check_eq("guard_fault", outv, 16'h7001);
    tick(); check_eq("guard_idle", outv, 16'h8001);
    check_eq("guard_depth", dut.depth_q, 0);
    tick(); check_eq("guard_sticky", outv, 16'h8001);
    reset = 1'b1;
    #1;
    check_eq("guard_rst", outv, 16'h0000);
    tick();
    reset = 1'b0;
    #1;
    check_eq("guard_cleared", outv, V_IDLE);
`else
    // RET at depth 0 runs unchecked; depth saturates at 0
    op_valid = 1'b1; op_code = 2'b01;
    tick();
    op_valid = 1'b0;
    check_eq("sat_c1", outv, V_POP);
    tick(); check_eq("sat_c2", outv, V_POP);
    tick(); check_eq("sat_c3", outv, V_LDPC);
    tick(); check_eq("sat_idle", outv, V_IDLE);
    check_eq("sat_depth", dut.depth_q, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
